// File: rtl/pe_array_acc.sv
// pe_array_acc: signed MAC array with pipelined adder tree and K-tiled output-stationary accumulator
// Ports: clk/rst (sync, active-low); in_valid/in_ready/in_first/in_last/relu_en with ifmap (N_IN lanes),
// weight (lane i, channel o at i*N_OUT+o) and bias (per channel) form the input beat;
// ofmap/out_valid/out_ready form the result handshake; seq_err pulses on framing errors; busy flags activity.
module pe_array_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int N_IN  = 8,
  parameter int N_OUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          relu_en,
  input  logic [N_IN*IN_W-1:0]          ifmap,
  input  logic [N_IN*N_OUT*IN_W-1:0]    weight,
  input  logic [N_OUT*ACC_W-1:0]        bias,
  output logic [N_OUT*ACC_W-1:0]        ofmap,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          seq_err,
  output logic                          busy
);
  localparam int LV = $clog2(N_IN);
  localparam int P  = 1 << LV;
  localparam int NN = 2*P - 1;
  typedef enum logic {IDLE, ACCUM} state_e;
  // Heap-ordered tree per channel: node k sums nodes 2k+1 and 2k+2, leaves at P-1.., root at 0.
  // Every node is a register, so each tree level adds one pipeline stage.
  logic [ACC_W-1:0]       node_q [N_OUT][NN];
  logic [ACC_W-1:0]       node_d [N_OUT][NN];
  logic signed [2*IN_W-1:0] p;
  // Beat sideband, stage s aligned with tree depth LV-s; stage LV pairs with the root.
  logic [LV:0]            v_q, f_q, l_q, r_q;
  logic [N_OUT*ACC_W-1:0] b_q [LV+1];
  logic [ACC_W-1:0]       acc_q [N_OUT];
  logic [ACC_W-1:0]       sum_d [N_OUT];
  logic [N_OUT*ACC_W-1:0] ofmap_q;
  logic                   out_valid_q, seq_err_q, err_d, stall;
  state_e                 state_q;
  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = rst & ~stall;
  assign ofmap     = ofmap_q;
  assign out_valid = out_valid_q;
  assign seq_err   = seq_err_q;
  assign busy      = |v_q || state_q == ACCUM || out_valid_q;
  always_comb begin
    p = '0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k < P-1; k++) node_d[o][k] = node_q[o][2*k+1] + node_q[o][2*k+2];
      for (int i = 0; i < P; i++) node_d[o][P-1+i] = '0;
      for (int i = 0; i < N_IN; i++) begin
        p = $signed(ifmap[i*IN_W +: IN_W]) * $signed(weight[(i*N_OUT+o)*IN_W +: IN_W]);
        node_d[o][P-1+i] = {{(ACC_W-2*IN_W){p[2*IN_W-1]}}, p};
      end
    end
  end
  // A first beat seeds from bias; a stray non-first beat while idle starts from zero.
  always_comb begin
    err_d = v_q[LV] && (f_q[LV] ? state_q == ACCUM : state_q == IDLE);
    for (int o = 0; o < N_OUT; o++)
      sum_d[o] = (f_q[LV] ? b_q[LV][o*ACC_W +: ACC_W] : state_q == ACCUM ? acc_q[o] : '0) + node_q[o][0];
  end
  always_ff @(posedge clk) begin
    if (!stall) begin
      f_q <= {f_q[LV-1:0], in_first};
      l_q <= {l_q[LV-1:0], in_last};
      r_q <= {r_q[LV-1:0], relu_en};
      b_q[0] <= bias;
      for (int s = 1; s <= LV; s++) b_q[s] <= b_q[s-1];
      for (int o = 0; o < N_OUT; o++)
        for (int k = 0; k < NN; k++) node_q[o][k] <= node_d[o][k];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q         <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      ofmap_q     <= '0;
      for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
    end else begin
      seq_err_q <= !stall && err_d;
      if (!stall) begin
        v_q         <= {v_q[LV-1:0], in_valid & in_ready};
        out_valid_q <= v_q[LV] && l_q[LV];
        if (v_q[LV]) begin
          state_q <= l_q[LV] ? IDLE : ACCUM;
          for (int o = 0; o < N_OUT; o++) begin
            acc_q[o] <= sum_d[o];
            if (l_q[LV]) ofmap_q[o*ACC_W +: ACC_W] <= (r_q[LV] && sum_d[o][ACC_W-1]) ? '0 : sum_d[o];
          end
        end
      end
    end
  end
endmodule
